// File: rtl/axi_node_pkg.sv
`default_nettype none
// ============================================================================
// Module : axi_node_pkg
// Brief  : AXI node shared constants and error-responder state encoding.
// Rev    : 1.0
// ============================================================================
package axi_node_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int AXI_LEN_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        RESP  = 2'd2
    } err_state_e;

endpackage : axi_node_pkg
`default_nettype wire

// File: rtl/axi_r_error_responder.sv
`default_nettype none
// ============================================================================
// Module : axi_r_error_responder
// Brief  : Answers an undecodable AR with a full DECERR burst once the port
//          has drained, then grants the decoder on the last beat.
// Rev    : 1.0
// ============================================================================
module axi_r_error_responder
    import axi_node_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_USER_WIDTH = 6,
    parameter int AXI_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sample_ardata_info_i,
    input  logic [AXI_ID_WIDTH-1:0]   arid_i,
    input  logic [AXI_LEN_WIDTH-1:0]  arlen_i,
    input  logic [AXI_USER_WIDTH-1:0] aruser_i,
    input  logic                      outstanding_trans_i,
    output logic                      error_gnt_o,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    output logic [AXI_ID_WIDTH-1:0]   rid_o,
    output logic [AXI_DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]                rresp_o,
    output logic                      rlast_o,
    output logic [AXI_USER_WIDTH-1:0] ruser_o,
    output logic                      busy_o
);

    err_state_e                state_q, state_d;
    logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
    logic [AXI_USER_WIDTH-1:0] user_q, user_d;
    logic [AXI_LEN_WIDTH-1:0]  len_q, len_d;
    logic [AXI_LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;

    logic handshake;
    logic last_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            id_q       <= '0;
            user_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            user_q     <= user_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // The counter compare stops at the captured length, so arlen=255 never wraps.
    assign last_beat = (beat_cnt_q == len_q);
    assign handshake = rvalid_o & rready_i;

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        user_d     = user_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (sample_ardata_info_i) begin
                    id_d       = arid_i;
                    user_d     = aruser_i;
                    len_d      = arlen_i;
                    beat_cnt_d = '0;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (!outstanding_trans_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (handshake) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rvalid_o    = (state_q == RESP);
    assign rlast_o     = rvalid_o & last_beat;
    assign error_gnt_o = handshake & last_beat;
    assign busy_o      = (state_q != IDLE);
    assign rid_o       = id_q;
    assign ruser_o     = user_q;
    assign rdata_o     = '0;
    assign rresp_o     = RESP_DECERR;

`ifndef SYNTHESIS
    // The decoder only strobes from OPERATIVE, which maps onto our IDLE.
    a_sample_only_in_idle : assert property (
        @(posedge clk) disable iff (!rst_n)
        sample_ardata_info_i |-> (state_q == IDLE)
    ) else $error("sample_ardata_info_i asserted outside IDLE");
`endif

endmodule : axi_r_error_responder
`default_nettype wire

// File: tb/tb_axi_r_error_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_r_error_responder
// Brief  : Scoreboard bench for the AXI R-channel DECERR responder.
// Rev    : 1.0
// ============================================================================
module tb_axi_r_error_responder;
    import axi_node_pkg::*;

    localparam int IDW = 6;
    localparam int UW  = 6;
    localparam int DW  = 64;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           sample_ardata_info_i;
    logic [IDW-1:0] arid_i;
    logic [7:0]     arlen_i;
    logic [UW-1:0]  aruser_i;
    logic           outstanding_trans_i;
    logic           error_gnt_o;
    logic           rvalid_o;
    logic           rready_i;
    logic [IDW-1:0] rid_o;
    logic [DW-1:0]  rdata_o;
    logic [1:0]     rresp_o;
    logic           rlast_o;
    logic [UW-1:0]  ruser_o;
    logic           busy_o;

    axi_r_error_responder #(
        .AXI_ID_WIDTH   (IDW),
        .AXI_USER_WIDTH (UW),
        .AXI_DATA_WIDTH (DW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .sample_ardata_info_i (sample_ardata_info_i),
        .arid_i               (arid_i),
        .arlen_i              (arlen_i),
        .aruser_i             (aruser_i),
        .outstanding_trans_i  (outstanding_trans_i),
        .error_gnt_o          (error_gnt_o),
        .rvalid_o             (rvalid_o),
        .rready_i             (rready_i),
        .rid_o                (rid_o),
        .rdata_o              (rdata_o),
        .rresp_o              (rresp_o),
        .rlast_o              (rlast_o),
        .ruser_o              (ruser_o),
        .busy_o               (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [UW-1:0]  user;
        logic           last;
    } beat_t;

    beat_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Results of the most recent collect() call
    int obs_beats;
    int first_valid;
    int gnt_count;
    int stall_faults;
    int spurious_gnt;
    bit timed_out;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Strobe one erroneous AR and push its arlen+1 expected beats.
    task automatic capture(input logic [IDW-1:0] id, input logic [7:0] len,
                           input logic [UW-1:0] user);
        beat_t e;
        sample_ardata_info_i = 1'b1;
        arid_i   = id;
        arlen_i  = len;
        aruser_i = user;
        for (int b = 0; b <= int'(len); b++) begin
            e.id   = id;
            e.user = user;
            e.last = (b == int'(len));
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        sample_ardata_info_i = 1'b0;
        arid_i   = ~id;
        arlen_i  = ~len;
        aruser_i = ~user;
    endtask

    // Runs cycles from the current one, driving rready from pat (indexed by
    // cycles with rvalid high); every handshake is popped from the scoreboard.
    task automatic collect(input int max_cycles, input int stop_beats,
                           input logic [7:0] pat, input int pat_len);
        beat_t          e;
        bit             prev_stall;
        bit             done;
        logic [IDW-1:0] pid;
        logic [UW-1:0]  pu;
        logic           pl;
        int             k;
        obs_beats    = 0;
        first_valid  = -1;
        gnt_count    = 0;
        stall_faults = 0;
        spurious_gnt = 0;
        timed_out    = 1'b1;
        prev_stall   = 1'b0;
        done         = 1'b0;
        k            = 0;
        pid = '0; pu = '0; pl = 1'b0;
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            rready_i = pat[k % pat_len];
            #1;
            if (error_gnt_o && !(rvalid_o && rready_i)) spurious_gnt++;
            if (rvalid_o) begin
                if (first_valid < 0) first_valid = cyc;
                if (prev_stall && (rid_o !== pid || ruser_o !== pu || rlast_o !== pl))
                    stall_faults++;
                if (rready_i) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat_unexpected: got rid=%h rlast=%b, required no beat",
                                 rid_o, rlast_o);
                    end else begin
                        e = exp_q.pop_front();
                        if ({rid_o, ruser_o, rlast_o, rresp_o, rdata_o, error_gnt_o} !==
                            {e.id, e.user, e.last, RESP_DECERR, {DW{1'b0}}, e.last}) begin
                            errors++;
                            $display("FAIL beat%0d: got id=%h user=%h last=%b resp=%b data=%h gnt=%b, required id=%h user=%h last=%b resp=11 data=0 gnt=%b",
                                     obs_beats, rid_o, ruser_o, rlast_o, rresp_o, rdata_o,
                                     error_gnt_o, e.id, e.user, e.last, e.last);
                        end
                    end
                    obs_beats++;
                    if (error_gnt_o) gnt_count++;
                    prev_stall = 1'b0;
                    if (rlast_o || obs_beats == stop_beats) done = 1'b1;
                end else begin
                    prev_stall = 1'b1;
                    pid = rid_o;
                    pu  = ruser_o;
                    pl  = rlast_o;
                end
                k++;
            end
            @(posedge clk); #1;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
        rready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sample_ardata_info_i = 1'b0;
        arid_i = '0; arlen_i = '0; aruser_i = '0;
        outstanding_trans_i = 1'b0;
        rready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rvalid_o, rlast_o, error_gnt_o, busy_o, rid_o, ruser_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b last=%b gnt=%b busy=%b id=%h user=%h, required all 0",
                     rvalid_o, rlast_o, error_gnt_o, busy_o, rid_o, ruser_o);
        end
        checks++;
        if (rresp_o !== RESP_DECERR || rdata_o !== '0) begin
            errors++;
            $display("FAIL reset_consts: got resp=%b data=%h, required resp=11 data=0", rresp_o, rdata_o);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy_o !== 1'b0 || rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b valid=%b, required 0 0", busy_o, rvalid_o);
        end
    endtask

    task automatic test_single_beat();
        outstanding_trans_i = 1'b0;
        capture(6'h2A, 8'd0, 6'h05);
        collect(20, 0, 8'hFF, 1);
        checks++;
        if (timed_out || obs_beats != 1 || first_valid != 1) begin
            errors++;
            $display("FAIL single_beat: got beats=%0d first_valid=%0d timeout=%b, required beats=1 first_valid=1 timeout=0",
                     obs_beats, first_valid, timed_out);
        end
        checks++;
        if (gnt_count != 1 || spurious_gnt != 0 || busy_o !== 1'b0 || rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_gnt: got gnt=%0d spurious=%0d busy=%b valid=%b, required 1 0 0 0",
                     gnt_count, spurious_gnt, busy_o, rvalid_o);
        end
    endtask

    task automatic test_drain();
        int early;
        early = 0;
        outstanding_trans_i = 1'b1;
        capture(6'h15, 8'd3, 6'h2B);
        rready_i = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (rvalid_o !== 1'b0 || busy_o !== 1'b1 || error_gnt_o !== 1'b0) early++;
            @(posedge clk); #1;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL drain_hold: got %0d bad cycles while outstanding, required 0", early);
        end
        outstanding_trans_i = 1'b0;
        collect(30, 0, 8'hFF, 1);
        checks++;
        if (timed_out || obs_beats != 4 || first_valid != 1 || gnt_count != 1 || spurious_gnt != 0) begin
            errors++;
            $display("FAIL drain_burst: got beats=%0d first_valid=%0d gnt=%0d spurious=%0d, required 4 1 1 0",
                     obs_beats, first_valid, gnt_count, spurious_gnt);
        end
    endtask

    task automatic test_backpressure();
        outstanding_trans_i = 1'b0;
        capture(6'h0F, 8'd2, 6'h30);
        // rready sequence 0,1,0,0,1,1 once rvalid is up
        collect(30, 0, 8'b0011_0010, 6);
        checks++;
        if (timed_out || obs_beats != 3 || stall_faults != 0) begin
            errors++;
            $display("FAIL backpressure: got beats=%0d stall_faults=%0d, required 3 0",
                     obs_beats, stall_faults);
        end
        checks++;
        if (gnt_count != 1 || spurious_gnt != 0) begin
            errors++;
            $display("FAIL bp_gnt: got gnt=%0d spurious=%0d, required 1 0", gnt_count, spurious_gnt);
        end
    endtask

    task automatic test_max_len();
        outstanding_trans_i = 1'b0;
        capture(6'h01, 8'd255, 6'h3E);
        collect(300, 0, 8'hFF, 1);
        checks++;
        if (timed_out || obs_beats != 256 || gnt_count != 1 || spurious_gnt != 0) begin
            errors++;
            $display("FAIL max_len: got beats=%0d gnt=%0d spurious=%0d timeout=%b, required 256 1 0 0",
                     obs_beats, gnt_count, spurious_gnt, timed_out);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL max_len_busy: got busy=%b after last beat, required 0", busy_o);
        end
    endtask

    task automatic test_reset_mid_burst();
        outstanding_trans_i = 1'b0;
        capture(6'h0C, 8'd7, 6'h11);
        collect(30, 3, 8'hFF, 1);
        checks++;
        if (timed_out || obs_beats != 3 || rvalid_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_partial: got beats=%0d valid=%b, required 3 1", obs_beats, rvalid_o);
        end
        rready_i = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rvalid_o !== 1'b0 || busy_o !== 1'b0 || error_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b busy=%b gnt=%b, required 0 0 0",
                     rvalid_o, busy_o, error_gnt_o);
        end
        exp_q.delete();
        rready_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        capture(6'h27, 8'd1, 6'h09);
        collect(30, 0, 8'hFF, 1);
        checks++;
        if (timed_out || obs_beats != 2 || gnt_count != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset: got beats=%0d gnt=%0d left=%0d, required 2 1 0",
                     obs_beats, gnt_count, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        outstanding_trans_i = 1'b0;
        capture(6'h33, 8'd1, 6'h01);
        collect(30, 0, 8'hFF, 1);
        checks++;
        if (timed_out || obs_beats != 2 || gnt_count != 1) begin
            errors++;
            $display("FAIL b2b_first: got beats=%0d gnt=%0d, required 2 1", obs_beats, gnt_count);
        end
        checks++;
        if (error_gnt_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: got gnt=%b busy=%b between bursts, required 0 0", error_gnt_o, busy_o);
        end
        capture(6'h11, 8'd2, 6'h22);
        collect(30, 0, 8'hFF, 1);
        checks++;
        if (timed_out || obs_beats != 3 || first_valid != 1 || gnt_count != 1 ||
            spurious_gnt != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_second: got beats=%0d first_valid=%0d gnt=%0d spurious=%0d left=%0d, required 3 1 1 0 0",
                     obs_beats, first_valid, gnt_count, spurious_gnt, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_drain();
        test_backpressure();
        test_max_len();
        test_reset_mid_burst();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_axi_r_error_responder
`default_nettype wire
